// File: rtl/rssi_agc_pkg.sv
// Shared types and constants for the RSSI-driven AGC sequencer.
// Optional feature macro used by the top: RSSI_AGC_FAST_ATTACK_EN.
package rssi_agc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_MEASURE = 2'd2,
      ST_DECIDE  = 2'd3
   } agc_state_e;

   localparam int TIMER_W          = 16;
   localparam int FAST_ATTACK_MULT = 4;
   localparam int GAIN_EXT_PAD     = 3;

   // Headroom so gain +/- step never wraps before the clamp.
   function automatic int gain_ext_w(input int gain_w);
      return gain_w + GAIN_EXT_PAD;
   endfunction

   typedef struct packed {
      logic overload;
      logic hi;
      logic lo;
   } agc_cmp_t;

endpackage

// File: rtl/agc_dwell_timer.sv
// Load/decrement down-counter shared by the SETTLE and MEASURE windows.
module agc_dwell_timer
   import rssi_agc_pkg::*;
(
   input  logic               clock_i,
   input  logic               reset_n_i,
   input  logic               load_i,
   input  logic [TIMER_W-1:0] load_val_i,
   input  logic               dec_i,
   output logic               zero_o
);

   logic [TIMER_W-1:0] count_q;

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/rssi_agc_ctrl.sv
// Closed-loop AGC sequencer: clear/settle, measure, then step the gain code.
// Define RSSI_AGC_FAST_ATTACK_EN to make overload step down by FAST_ATTACK_MULT*STEP.
module rssi_agc_ctrl
   import rssi_agc_pkg::*;
#(
   parameter int GAIN_W = 7,
   parameter int STEP   = 1
) (
   input  logic              clock_i,
   input  logic              reset_n_i,
   input  logic              enable_i,
   input  logic [15:0]       rssi_i,
   input  logic [15:0]       over_count_i,
   input  logic [15:0]       settle_cycles_i,
   input  logic [15:0]       dwell_cycles_i,
   input  logic [15:0]       rssi_hi_i,
   input  logic [15:0]       rssi_lo_i,
   input  logic [15:0]       over_thresh_i,
   input  logic [GAIN_W-1:0] gain_min_i,
   input  logic [GAIN_W-1:0] gain_max_i,
   input  logic [GAIN_W-1:0] gain_init_i,
   output logic              meas_clear_o,
   output logic [GAIN_W-1:0] gain_o,
   output logic              gain_stb_o,
   output logic              locked_o
);

   localparam int EXT_W = gain_ext_w(GAIN_W);
`ifdef RSSI_AGC_FAST_ATTACK_EN
   localparam int OVL_MULT = FAST_ATTACK_MULT;
`else
   localparam int OVL_MULT = 1;
`endif
   localparam logic signed [EXT_W-1:0] STEP_X     = EXT_W'(STEP);
   localparam logic signed [EXT_W-1:0] OVL_STEP_X = EXT_W'(STEP * OVL_MULT);

   agc_state_e        state_q;
   logic [GAIN_W-1:0] gain_q;
   logic              gain_stb_q;
   logic              locked_q;
   logic              meas_clear_q;

   logic               timer_load;
   logic [TIMER_W-1:0] timer_val;
   logic               timer_dec;
   logic               timer_zero;

   agc_cmp_t                 cmp;
   logic signed [EXT_W-1:0]  gain_x, min_x, max_x, target_x, clamp_x;
   logic [GAIN_W-1:0]        gain_d;
   logic                     gain_changed;
   logic                     in_range;

   // Decision datapath: only consumed in DECIDE, evaluated every cycle.
   assign cmp.overload = (over_count_i > over_thresh_i);
   assign cmp.hi       = (rssi_i > rssi_hi_i);
   assign cmp.lo       = (rssi_i < rssi_lo_i);
   assign in_range     = ~(cmp.overload | cmp.hi | cmp.lo);

   assign gain_x = $signed({{(EXT_W-GAIN_W){1'b0}}, gain_q});
   assign min_x  = $signed({{(EXT_W-GAIN_W){1'b0}}, gain_min_i});
   assign max_x  = $signed({{(EXT_W-GAIN_W){1'b0}}, gain_max_i});

   always_comb begin
      target_x = gain_x;
      if (cmp.overload) begin
         target_x = gain_x - OVL_STEP_X;
      end else if (cmp.hi) begin
         target_x = gain_x - STEP_X;
      end else if (cmp.lo) begin
         target_x = gain_x + STEP_X;
      end
   end

   // Max is applied last so an inverted min/max config resolves to gain_max.
   always_comb begin
      clamp_x = target_x;
      if (clamp_x < min_x) clamp_x = min_x;
      if (clamp_x > max_x) clamp_x = max_x;
   end

   assign gain_changed = (clamp_x != gain_x);
   assign gain_d       = clamp_x[GAIN_W-1:0];

   always_comb begin
      timer_load = 1'b0;
      timer_val  = '0;
      timer_dec  = 1'b0;
      if (!enable_i) begin
         timer_load = 1'b1;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               timer_load = 1'b1;
               timer_val  = settle_cycles_i;
            end
            ST_SETTLE: begin
               if (timer_zero) begin
                  timer_load = 1'b1;
                  timer_val  = dwell_cycles_i;
               end else begin
                  timer_dec = 1'b1;
               end
            end
            ST_MEASURE: timer_dec = 1'b1;
            ST_DECIDE: begin
               timer_load = 1'b1;
               timer_val  = gain_changed ? settle_cycles_i : dwell_cycles_i;
            end
            default: ;
         endcase
      end
   end

   agc_dwell_timer u_timer (
      .clock_i    (clock_i),
      .reset_n_i  (reset_n_i),
      .load_i     (timer_load),
      .load_val_i (timer_val),
      .dec_i      (timer_dec),
      .zero_o     (timer_zero)
   );

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q      <= ST_IDLE;
         gain_q       <= '0;
         gain_stb_q   <= 1'b0;
         locked_q     <= 1'b0;
         meas_clear_q <= 1'b1;
      end else begin
         gain_stb_q <= 1'b0;
         if (!enable_i) begin
            state_q      <= ST_IDLE;
            gain_q       <= gain_init_i;
            locked_q     <= 1'b0;
            meas_clear_q <= 1'b1;
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  state_q      <= ST_SETTLE;
                  gain_q       <= gain_init_i;
                  locked_q     <= 1'b0;
                  meas_clear_q <= 1'b1;
               end
               ST_SETTLE: begin
                  if (timer_zero) begin
                     state_q      <= ST_MEASURE;
                     meas_clear_q <= 1'b0;
                  end
               end
               ST_MEASURE: begin
                  if (timer_zero) state_q <= ST_DECIDE;
               end
               ST_DECIDE: begin
                  if (gain_changed) begin
                     state_q      <= ST_SETTLE;
                     gain_q       <= gain_d;
                     gain_stb_q   <= 1'b1;
                     locked_q     <= 1'b0;
                     meas_clear_q <= 1'b1;
                  end else begin
                     // Averager keeps running: no clear on a hold decision.
                     state_q  <= ST_MEASURE;
                     locked_q <= in_range;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign meas_clear_o = meas_clear_q;
   assign gain_o       = gain_q;
   assign gain_stb_o   = gain_stb_q;
   assign locked_o     = locked_q;

endmodule

// File: tb/tb_rssi_agc_ctrl.sv
// Bench for rssi_agc_ctrl: cycle model of the AGC loop plus directed literal checks.
module tb_rssi_agc_ctrl;

   localparam int GAIN_W = 7;
   localparam int STEP   = 1;
`ifdef RSSI_AGC_FAST_ATTACK_EN
   localparam int OVL_DOWN = 4 * STEP;
`else
   localparam int OVL_DOWN = STEP;
`endif

   logic              clock = 1'b0;
   logic              reset_n = 1'b1;
   logic              enable;
   logic [15:0]       rssi, over_count, settle_cycles, dwell_cycles;
   logic [15:0]       rssi_hi, rssi_lo, over_thresh;
   logic [GAIN_W-1:0] gain_min, gain_max, gain_init;
   logic              meas_clear, gain_stb, locked;
   logic [GAIN_W-1:0] gain;

   int total = 0;
   int bad   = 0;
   int stb_seen;

   always #5 clock = ~clock;

   rssi_agc_ctrl #(.GAIN_W(GAIN_W), .STEP(STEP)) dut (
      .clock_i         (clock),
      .reset_n_i       (reset_n),
      .enable_i        (enable),
      .rssi_i          (rssi),
      .over_count_i    (over_count),
      .settle_cycles_i (settle_cycles),
      .dwell_cycles_i  (dwell_cycles),
      .rssi_hi_i       (rssi_hi),
      .rssi_lo_i       (rssi_lo),
      .over_thresh_i   (over_thresh),
      .gain_min_i      (gain_min),
      .gain_max_i      (gain_max),
      .gain_init_i     (gain_init),
      .meas_clear_o    (meas_clear),
      .gain_o          (gain),
      .gain_stb_o      (gain_stb),
      .locked_o        (locked)
   );

   // Model: phase plus cycles left in the current window, integer gain arithmetic.
   localparam int P_IDLE = 0, P_SETTLE = 1, P_MEAS = 2, P_DEC = 3;
   int m_phase = P_IDLE;
   int m_left  = 0;
   int m_gain  = 0;
   int m_tgt;
   bit m_stb  = 1'b0;
   bit m_lock = 1'b0;
   bit m_clr  = 1'b1;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_phase = P_IDLE; m_left = 0; m_gain = 0;
         m_stb = 1'b0; m_lock = 1'b0; m_clr = 1'b1;
      end else begin
         m_stb = 1'b0;
         if (!enable) begin
            m_phase = P_IDLE; m_gain = int'(gain_init); m_lock = 1'b0; m_clr = 1'b1;
         end else begin
            case (m_phase)
               P_IDLE: begin
                  m_gain = int'(gain_init); m_lock = 1'b0; m_clr = 1'b1;
                  m_phase = P_SETTLE; m_left = int'(settle_cycles) + 1;
               end
               P_SETTLE: begin
                  m_left--;
                  if (m_left == 0) begin
                     m_phase = P_MEAS; m_left = int'(dwell_cycles) + 1; m_clr = 1'b0;
                  end
               end
               P_MEAS: begin
                  m_left--;
                  if (m_left == 0) m_phase = P_DEC;
               end
               default: begin
                  if (over_count > over_thresh)  m_tgt = m_gain - OVL_DOWN;
                  else if (rssi > rssi_hi)       m_tgt = m_gain - STEP;
                  else if (rssi < rssi_lo)       m_tgt = m_gain + STEP;
                  else                           m_tgt = m_gain;
                  if (m_tgt < int'(gain_min)) m_tgt = int'(gain_min);
                  if (m_tgt > int'(gain_max)) m_tgt = int'(gain_max);
                  if (m_tgt != m_gain) begin
                     m_gain = m_tgt; m_stb = 1'b1; m_lock = 1'b0; m_clr = 1'b1;
                     m_phase = P_SETTLE; m_left = int'(settle_cycles) + 1;
                  end else begin
                     m_lock = (over_count <= over_thresh) && (rssi <= rssi_hi) && (rssi >= rssi_lo);
                     m_phase = P_MEAS; m_left = int'(dwell_cycles) + 1;
                  end
               end
            endcase
         end
      end
   end

   always @(negedge clock) begin
      total++;
      if (int'(gain) != m_gain || gain_stb !== m_stb || locked !== m_lock || meas_clear !== m_clr) begin
         bad++;
         $display("FAIL model @%0t: gain %0d want %0d, stb %0b want %0b, locked %0b want %0b, clear %0b want %0b",
                  $time, gain, m_gain, gain_stb, m_stb, locked, m_lock, meas_clear, m_clr);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic clear_run(input int val, input int n, input string name);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         chk(name, int'(meas_clear), val);
         if (gain_stb === 1'b1) stb_seen++;
      end
   endtask

   // Drop to IDLE, re-enable, walk SETTLE (4) + MEASURE (8) + DECIDE, stop one cycle after DECIDE.
   task automatic restart_to_decision(input string name);
      @(posedge clock); #2 enable = 1'b0;
      @(posedge clock); #2 enable = 1'b1;
      @(posedge clock);
      stb_seen = 0;
      clear_run(1, 4, {name, "_settle_clear"});
      clear_run(0, 9, {name, "_measure_clear"});
      chk({name, "_no_early_stb"}, stb_seen, 0);
      @(negedge clock);
   endtask

   initial begin
      enable = 1'b0; rssi = 16'd1000; over_count = 16'd0;
      settle_cycles = 16'd3; dwell_cycles = 16'd7;
      rssi_hi = 16'd2000; rssi_lo = 16'd500; over_thresh = 16'd1000;
      gain_min = 7'd0; gain_max = 7'd63; gain_init = 7'd40;
      #1 reset_n = 1'b0;
      @(negedge clock);
      chk("reset_gain", int'(gain), 0);
      chk("reset_clear", int'(meas_clear), 1);
      chk("reset_locked", int'(locked), 0);
      chk("reset_stb", int'(gain_stb), 0);
      @(posedge clock); #2 reset_n = 1'b1;

      // In-window rssi: lock and keep measuring.
      restart_to_decision("lock");
      chk("lock_gain", int'(gain), 40);
      chk("lock_locked", int'(locked), 1);
      chk("lock_stb", int'(gain_stb), 0);
      chk("lock_no_clear", int'(meas_clear), 0);

      // Too loud: one step down with a single strobe and a fresh settle window.
      rssi = 16'd3000;
      restart_to_decision("hi");
      chk("hi_gain", int'(gain), 39);
      chk("hi_stb", int'(gain_stb), 1);
      chk("hi_locked", int'(locked), 0);
      chk("hi_clear", int'(meas_clear), 1);
      stb_seen = 0;
      clear_run(1, 3, "hi_resettle_clear");
      chk("hi_single_stb", stb_seen, 0);

      // Boundaries: equal to a threshold is not out of range.
      rssi = 16'd2000;
      restart_to_decision("eq_hi");
      chk("eq_hi_gain", int'(gain), 40);
      chk("eq_hi_locked", int'(locked), 1);
      rssi = 16'd500;
      restart_to_decision("eq_lo");
      chk("eq_lo_gain", int'(gain), 40);
      chk("eq_lo_locked", int'(locked), 1);

      // Quiet at max gain: clamped, no step, no strobe, stays measuring.
      rssi = 16'd100; gain_init = 7'd63; gain_max = 7'd63;
      restart_to_decision("max");
      chk("max_gain", int'(gain), 63);
      chk("max_locked", int'(locked), 0);
      chk("max_stb", int'(gain_stb), 0);
      chk("max_no_settle", int'(meas_clear), 0);

      // Overload near the floor.
      rssi = 16'd1000; gain_init = 7'd2; over_count = 16'd5000;
      restart_to_decision("ovl");
`ifdef RSSI_AGC_FAST_ATTACK_EN
      chk("ovl_gain", int'(gain), 0);
`else
      chk("ovl_gain", int'(gain), 1);
`endif
      chk("ovl_stb", int'(gain_stb), 1);
      chk("ovl_locked", int'(locked), 0);

      // Abort during SETTLE.
      over_count = 16'd0; gain_init = 7'd20;
      @(posedge clock); #2 enable = 1'b0;
      @(posedge clock); #2 enable = 1'b1;
      @(posedge clock); #2;
      @(posedge clock); #2 enable = 1'b0; gain_init = 7'd25;
      @(negedge clock);
      chk("abort_pre_gain", int'(gain), 20);
      @(negedge clock);
      chk("abort_gain", int'(gain), 25);
      chk("abort_clear", int'(meas_clear), 1);
      chk("abort_stb", int'(gain_stb), 0);
      chk("abort_locked", int'(locked), 0);

      // Async reset while locked in MEASURE.
      gain_init = 7'd40;
      restart_to_decision("pre_rst");
      chk("pre_rst_locked", int'(locked), 1);
      @(posedge clock); #2 reset_n = 1'b0;
      #1;
      chk("async_rst_gain", int'(gain), 0);
      chk("async_rst_locked", int'(locked), 0);
      chk("async_rst_clear", int'(meas_clear), 1);
      chk("async_rst_stb", int'(gain_stb), 0);
      @(posedge clock); #2 reset_n = 1'b1;
      repeat (4) @(posedge clock);
      @(negedge clock);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
